nibble_serial_add: RTL and testbench
====================================

# nibble_serial_add

Sequencer that performs a wide addition by driving the team's 4-bit ripple adder (`fulladd4`) one nibble per clock, least-significant first, and collecting its sum and carry. It sits on both sides of `fulladd4`: it feeds the adder's `a`, `b`, `Cin` inputs and consumes its `s`, `cout` outputs. The result is a registered multi-nibble sum with a start/done handshake.

## Interface
- `NIBBLES`, default 4: operand width in nibbles. `W = 4*NIBBLES`. Legal range is 1..16.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `a`  in  W  operand A; sampled on the accepted `start`.
- `b`  in  W  operand B; sampled on the accepted `start`.
- `cin`  in  1  carry-in; sampled on the accepted `start`.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid from this cycle.
- `sum`  out  W  registered result; held until the next accepted `start`.
- `cout`  out  1  registered final carry.
- `add_a`  out  4  to adder `a`.
- `add_b`  out  4  to adder `b`.
- `add_cin`  out  1  to adder `Cin`.
- `add_s`  in  4  from adder `s`.
- `add_cout`  in  1  from adder `cout`.
- The adder path is combinational. `add_s` and `add_cout` are valid in the same cycle that `add_a`/`add_b`/`add_cin` are driven.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE → RUN** on `start`=1.
  - Capture `a`, `b`, `cin` into `a_q`, `b_q`, `c_q`.
  - Clear nibble index `k` to 0.
  - Clear `sum` to 0 and `cout` to 0.
- **In RUN:**
  - Drive `add_a` = `a_q[4k+3:4k]`, `add_b` = `b_q[4k+3:4k]`, `add_cin` = `c_q`.
  - At each edge: `sum[4k+3:4k]` <= `add_s`, `c_q` <= `add_cout`, `k` <= `k`+1.
- **RUN → DONE** at the edge that captures nibble `NIBBLES-1`. That same edge loads `cout` <= `add_cout`.
- **DONE → IDLE** unconditionally after one cycle. `done`=1 only in DONE.
- **Handshake:**
  - `start` is ignored in RUN and DONE; it is not queued.
  - `start` held high in IDLE starts a new operation and overwrites `sum`/`cout`.
- **Adder drive outside RUN:** `add_a`, `add_b`, `add_cin` are driven 0.
- **Arithmetic:** unsigned, `{cout,sum}` = `a` + `b` + `cin` exactly (W+1 bits). The carry chain passes between nibbles only through `c_q`.
- **Reset:**
  - Any state, including mid-RUN, goes to IDLE.
  - `sum`=0, `cout`=0, `done`=0, `busy`=0, `ready`=1, `k`=0, `a_q`=`b_q`=0, `c_q`=0.
  - A partial result is discarded.
- `k` width is clog2(NIBBLES), minimum 1. `k` never wraps past `NIBBLES-1`.

## Timing
- Accepting edge: call it edge 0.
- RUN covers cycles 1..NIBBLES. Nibble k is captured at edge k+1.
- `done` is high in cycle NIBBLES+1, so latency from accepted `start` to `done` is NIBBLES+1 cycles.
- `ready` returns to 1 in cycle NIBBLES+2. The next `start` can be accepted at that edge.
- Throughput: one operation per NIBBLES+2 cycles.
- With `NIBBLES`=1: RUN lasts one cycle and `done` follows at cycle 2.

## Configuration
- **`SERIAL_ADD_OVF_EN`:**
  - **Defined:** adds output port `ovf` (1 bit, reset 0). It is registered alongside `cout` at the final RUN edge.
  - `ovf` = (`a_q[W-1]` == `b_q[W-1]`) && (`add_s[3]` != `a_q[W-1]`), i.e. two's-complement signed overflow.
  - `ovf` is cleared on accepted `start` and is valid with `done`.
  - **Undefined:** the `ovf` port and its logic are absent; all other behaviour is identical.

## Test plan
- `NIBBLES`=4, `a`=0x1234, `b`=0x4321, `cin`=0, with `start` at edge 0:
  - `done` in cycle 5; `sum`=0x5555, `cout`=0.
  - `add_a` sequence: 4, 3, 2, 1.
- `a`=0xFFFF, `b`=0x0001, `cin`=0 → `sum`=0x0000, `cout`=1. `add_cin` sequence is 0, 1, 1, 1.
- `a`=0xFFFF, `b`=0x0000, `cin`=1 → `sum`=0x0000, `cout`=1. Then `a`=0x0000, `b`=0x0000, `cin`=0 → `sum`=0, `cout`=0; stale carry must not leak.
- Pulse `start` in cycle 2 of an operation with different operands → ignored.
  - First result is unchanged and `done` arrives in cycle 5.
  - `start` in cycle 6 is accepted.
- Assert `rst` in cycle 3 of `a`=0xAAAA, `b`=0x5555 → immediately `busy`=0, `ready`=1, `sum`=0, `cout`=0, and no `done` pulse follows.
- With `SERIAL_ADD_OVF_EN`: `a`=0x7FFF, `b`=0x0001 → `sum`=0x8000, `ovf`=1, `cout`=0. Then `a`=0xFFFF, `b`=0x0001 → `ovf`=0, `cout`=1.

Source files
------------

// File: rtl/nibble_serial_add_if.sv
// Request/result bus of nibble_serial_add plus the link to the external 4-bit adder.
// SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
interface nibble_serial_add_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  // master: requester that also hosts the combinational adder
  modport master (
    output start, a, b, cin, add_s, add_cout,
    input  ready, busy, done, sum, cout, add_a, add_b, add_cin
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin, add_s, add_cout,
    output ready, busy, done, sum, cout, add_a, add_b, add_cin
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_add.sv
// Wide unsigned add performed one nibble per clock through an external 4-bit adder.
// Optional SERIAL_ADD_OVF_EN registers a two's-complement overflow flag with the final carry.
module nibble_serial_add #(
  parameter int NIBBLES = 4
) (
  input logic               clk,
  input logic               rst,
  nibble_serial_add_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_q, c_d;
  logic          cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic          last_nib;
  logic [KW+1:0] sh;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;

  assign last_nib = (k_q == KW'(NIBBLES - 1));
  assign sh       = {k_q, 2'b00};
  assign a_sh     = a_q >> sh;
  assign b_sh     = b_q >> sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        // Replace only the current nibble; the carry chain runs solely through c_q.
        sum_d = (sum_q & ~(W'(4'hF) << sh)) | (W'(bus.add_s) << sh);
        c_d   = bus.add_cout;
        if (last_nib) begin
          state_d = DONE;
          cout_d  = bus.add_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.add_a   = (state_q == RUN) ? a_sh[3:0] : 4'h0;
  assign bus.add_b   = (state_q == RUN) ? b_sh[3:0] : 4'h0;
  assign bus.add_cin = (state_q == RUN) ? c_q : 1'b0;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add.sv
// Directed bench for nibble_serial_add (NIBBLES=4) with a behavioural 4-bit adder on the bus.
module tb_nibble_serial_add;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_seen;

  always #5 clk = ~clk;

  nibble_serial_add_if #(.NIBBLES(4)) bus ();

  nibble_serial_add #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation starting in an IDLE cycle; es/ec are hand-computed results.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                        input logic [15:0] es, input logic ec, input string tag);
    logic       c;
    logic [4:0] t;
    bus.a = ta; bus.b = tbv; bus.cin = tc; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = tc;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_add_a"}, 32'(bus.add_a), 32'(ta[4*k +: 4]));
      chk({tag, "_add_cin"}, 32'(bus.add_cin), 32'(c));
      t = {1'b0, ta[4*k +: 4]} + {1'b0, tbv[4*k +: 4]} + {4'b0, c};
      c = t[4];
      tick();
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'((ta[15] == tbv[15]) && (es[15] != ta[15])));
`endif
    tick();
    chk({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
    chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "carry_ripple");
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "cin_ripple");
    run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "no_stale");

    // start pulsed mid-operation must be ignored
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.start = 1'b1;
    chk("ign_ready_c2", 32'(bus.ready), 32'd0);
    tick();
    bus.start = 1'b0;
    chk("ign_busy_c3", 32'(bus.busy), 32'd1);
    chk("ign_add_a_c3", 32'(bus.add_a), 32'h1);
    chk("ign_add_b_c3", 32'(bus.add_b), 32'h2);
    tick();
    chk("ign_done_c4", 32'(bus.done), 32'd0);
    tick();
    chk("ign_done_c5", 32'(bus.done), 32'd1);
    chk("ign_sum", 32'(bus.sum), 32'h3333);
    chk("ign_cout", 32'(bus.cout), 32'd0);
    tick();
    chk("ign_ready_c6", 32'(bus.ready), 32'd1);
    run_op(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, "back_to_back");

    // reset in cycle 3 discards the partial result
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("mid_sum_partial", 32'(bus.sum), 32'h00FF);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_cout", 32'(bus.cout), 32'd0);
    chk("mid_rst_add_a", 32'(bus.add_a), 32'd0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) done_seen++;
      tick();
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);
    chk("mid_rst_idle_sum", 32'(bus.sum), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "after_rst");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "signed_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "no_signed_ovf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
